// File: rtl/integer_exec_unit_pkg.sv
// Shared types for the integer execution unit: ALU opcodes, CDB entry
// layout and result-buffer occupancy encoding.
// Optional feature macro: INT_EXEC_SKID_EN (two-entry result buffer).
package integer_exec_unit_pkg;

   localparam int XLEN  = 32;
   localparam int TAG_W = 6;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SLL = 3'd5,
      ALU_SRL = 3'd6,
      ALU_SLT = 3'd7
   } alu_op_e;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  data;
   } cdb_entry_t;

`ifdef INT_EXEC_SKID_EN
   localparam int BUF_CAP = 2;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_HOLD  = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;
`else
   localparam int BUF_CAP = 1;

   typedef enum logic {
      OCC_EMPTY = 1'b0,
      OCC_HOLD  = 1'b1
   } occ_e;
`endif

endpackage

// File: rtl/integer_exec_unit_if.sv
// Issue-queue handshake and CDB broadcast bundle of the integer execution
// unit. The master side is the issue queue plus CDB arbiter; the slave side
// is the execution unit.
interface integer_exec_unit_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 6
);
   import integer_exec_unit_pkg::*;

   logic             issueque_ready;
   logic [XLEN-1:0]  issueque_rs_data;
   logic [XLEN-1:0]  issueque_rt_data;
   logic [TAG_W-1:0] issueque_rd_tag;
   alu_op_e          issueque_opcode;
   logic             issueblk_done;

   logic             cdb_req;
   logic             cdb_grant;
   logic             cdb_valid;
   logic [TAG_W-1:0] cdb_tag;
   logic [XLEN-1:0]  cdb_data;

   modport master (
      output issueque_ready, issueque_rs_data, issueque_rt_data,
             issueque_rd_tag, issueque_opcode, cdb_grant,
      input  issueblk_done, cdb_req, cdb_valid, cdb_tag, cdb_data
   );

   modport slave (
      input  issueque_ready, issueque_rs_data, issueque_rt_data,
             issueque_rd_tag, issueque_opcode, cdb_grant,
      output issueblk_done, cdb_req, cdb_valid, cdb_tag, cdb_data
   );

endinterface

// File: rtl/integer_exec_unit_int_alu.sv
// Purely combinational integer ALU feeding the result-buffer write port.
// All results wrap modulo 2^WIDTH; shifts use the low log2(WIDTH) bits of B.
module int_alu
   import integer_exec_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  alu_op_e          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result
);

   localparam int SHAMT_W = $clog2(WIDTH);

   logic [SHAMT_W-1:0] shamt;

   assign shamt = b[SHAMT_W-1:0];

   // Select the operation result for the presented opcode.
   always_comb begin
      // NOTE: default assignment first so no path through the block leaves
      // result unassigned, which would otherwise infer a latch.
      result = '0;
      case (op)
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         ALU_SLL: result = a << shamt;
         ALU_SRL: result = a >> shamt;
         ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/integer_exec_unit.sv
// Integer execution unit: accepts one instruction per cycle from the issue
// queue, computes the ALU result and holds it in an in-order result buffer
// until the CDB arbiter grants the bus, then broadcasts {tag, data}.
// Optional feature macro: INT_EXEC_SKID_EN grows the buffer from one to two
// entries so acceptance continues for one cycle of withheld grant.
module integer_exec_unit #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 6
) (
   input logic                clk,
   input logic                reset_n,
   integer_exec_unit_if.slave bus
);
   import integer_exec_unit_pkg::*;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  data;
   } entry_t;

   occ_e            occ;
   entry_t          head_q;
`ifdef INT_EXEC_SKID_EN
   entry_t          skid_q;
`endif
   entry_t          new_entry;
   logic [XLEN-1:0] alu_result;
   logic            has_room;
   logic            accept;
   logic            pop;

   int_alu #(.WIDTH(XLEN)) u_int_alu (
      .op     (bus.issueque_opcode),
      .a      (bus.issueque_rs_data),
      .b      (bus.issueque_rt_data),
      .result (alu_result)
   );

   assign new_entry = '{tag: bus.issueque_rd_tag, data: alu_result};

`ifdef INT_EXEC_SKID_EN
   assign has_room = (occ != OCC_FULL);
`else
   assign has_room = (occ == OCC_EMPTY);
`endif

   // A grant on an empty buffer is not a pop; a grant on a full buffer frees
   // the head slot in the same edge, so acceptance may ride on it.
   assign pop    = bus.cdb_grant && (occ != OCC_EMPTY);
   assign accept = bus.issueque_ready && (has_room || bus.cdb_grant);

   assign bus.issueblk_done = accept;
   assign bus.cdb_req       = (occ != OCC_EMPTY);
   assign bus.cdb_valid     = pop;
   // The head register is cleared whenever the buffer drains, so the CDB
   // fields read 0 while empty and depend only on state, never on inputs.
   assign bus.cdb_tag       = head_q.tag;
   assign bus.cdb_data      = head_q.data;

   // Occupancy FSM and result buffer: accept writes the tail, pop retires the head.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the buffer entries are reset as well as the state, because
         // the head drives the CDB fields directly and must read 0 when empty.
         occ    <= OCC_EMPTY;
         head_q <= '0;
`ifdef INT_EXEC_SKID_EN
         skid_q <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values and the shift head <= skid <= new is ordered correctly.
         case (occ)
            OCC_EMPTY: begin
               if (accept) begin
                  head_q <= new_entry;
                  occ    <= OCC_HOLD;
               end
            end
            OCC_HOLD: begin
               if (accept && pop) begin
                  head_q <= new_entry;
               end else if (pop) begin
                  head_q <= '0;
                  occ    <= OCC_EMPTY;
               end
`ifdef INT_EXEC_SKID_EN
               else if (accept) begin
                  skid_q <= new_entry;
                  occ    <= OCC_FULL;
               end
`endif
            end
`ifdef INT_EXEC_SKID_EN
            OCC_FULL: begin
               if (pop) begin
                  head_q <= skid_q;
                  if (accept) begin
                     skid_q <= new_entry;
                  end else begin
                     skid_q <= '0;
                     occ    <= OCC_HOLD;
                  end
               end
            end
`endif
            default: occ <= OCC_EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_integer_exec_unit.sv
// Self-checking bench for integer_exec_unit. A queue-based reference model
// is compared against the DUT every negative clock edge; directed vectors
// add hand-computed expectations. Build with +define+INT_EXEC_SKID_EN to
// exercise the two-entry buffer variant.
module tb_integer_exec_unit;
   import integer_exec_unit_pkg::*;

`ifdef INT_EXEC_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   typedef struct {
      alu_op_e     op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   logic clk;
   logic reset_n;
   int   n_checks = 0;
   int   n_errors = 0;

   integer_exec_unit_if #(.XLEN(32), .TAG_W(6)) bus ();

   integer_exec_unit #(.XLEN(32), .TAG_W(6)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
      int unsigned sh;
      sh = int'(b[4:0]);
      case (op)
         0:       return a + b;
         1:       return a - b;
         2:       return a & b;
         3:       return a | b;
         4:       return a ^ b;
         5:       return a << sh;
         6:       return a >> sh;
         default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      endcase
   endfunction

   // Reference model: an in-order queue of pending results bounded by CAP.
   cdb_entry_t mq[$];
   int         bcast_log[$];
   logic       m_done;
   logic       m_req;
   logic       m_valid;
   cdb_entry_t m_head;

   initial begin
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            mq.delete();
            check("rst_done",  64'(bus.issueblk_done), 64'd0);
            check("rst_req",   64'(bus.cdb_req),       64'd0);
            check("rst_valid", 64'(bus.cdb_valid),     64'd0);
            check("rst_tag",   64'(bus.cdb_tag),       64'd0);
            check("rst_data",  64'(bus.cdb_data),      64'd0);
         end else begin
            m_req   = (mq.size() != 0);
            m_done  = bus.issueque_ready && ((mq.size() < CAP) || bus.cdb_grant);
            m_valid = m_req && bus.cdb_grant;
            m_head  = m_req ? mq[0] : '0;
            check("model_done",  64'(bus.issueblk_done), 64'(m_done));
            check("model_req",   64'(bus.cdb_req),       64'(m_req));
            check("model_valid", 64'(bus.cdb_valid),     64'(m_valid));
            check("model_tag",   64'(bus.cdb_tag),       64'(m_head.tag));
            check("model_data",  64'(bus.cdb_data),      64'(m_head.data));
            if (bus.cdb_valid) bcast_log.push_back(int'(bus.cdb_tag));
            if (m_valid) void'(mq.pop_front());
            if (m_done) mq.push_back('{tag: bus.issueque_rd_tag,
                                       data: ref_alu(int'(bus.issueque_opcode),
                                                     bus.issueque_rs_data,
                                                     bus.issueque_rt_data)});
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rdy, input logic gnt, input logic [5:0] tag,
                        input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
      bus.issueque_ready   = rdy;
      bus.cdb_grant        = gnt;
      bus.issueque_rd_tag  = tag;
      bus.issueque_opcode  = op;
      bus.issueque_rs_data = a;
      bus.issueque_rt_data = b;
   endtask

   task automatic check_log(input string name, input int first_tag, input int n);
      check({name, "_len"}, 64'(bcast_log.size()), 64'(n));
      for (int i = 0; i < n && i < bcast_log.size(); i++)
         check({name, "_order"}, 64'(bcast_log[i]), 64'(first_tag + i));
   endtask

   vec_t vecs[8];
   int   tag_presented;

   initial begin
      vecs[0] = '{ALU_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
      vecs[1] = '{ALU_SLT, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001};
      vecs[2] = '{ALU_SRL, 32'h8000_0000, 32'd31,        32'h0000_0001};
      vecs[3] = '{ALU_SLL, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002};
      vecs[4] = '{ALU_XOR, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5};
      vecs[5] = '{ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
      vecs[6] = '{ALU_OR,  32'h0F0F_0000, 32'h0000_00FF, 32'h0F0F_00FF};
      vecs[7] = '{ALU_SLT, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000};

      reset_n = 1'b0;
      drive(1'b0, 1'b0, 6'd0, ALU_ADD, 32'd0, 32'd0);
      repeat (3) cyc();
      reset_n = 1'b1;

      // Idle after reset: nothing requested, nothing accepted.
      for (int i = 0; i < 10; i++) begin
         cyc();
         #3;
         check("idle_req",  64'(bus.cdb_req),       64'd0);
         check("idle_done", 64'(bus.issueblk_done), 64'd0);
      end

      // Grant pulse on an empty buffer is ignored.
      cyc();
      drive(1'b0, 1'b1, 6'd0, ALU_ADD, 32'd0, 32'd0);
      #3;
      check("empty_grant_valid", 64'(bus.cdb_valid), 64'd0);
      cyc();
      drive(1'b0, 1'b0, 6'd0, ALU_ADD, 32'd0, 32'd0);
      #3;
      check("empty_grant_req", 64'(bus.cdb_req), 64'd0);

      // ADD 5+7 with grant held: broadcast one cycle after acceptance.
      cyc();
      drive(1'b1, 1'b1, 6'h0A, ALU_ADD, 32'd5, 32'd7);
      #3;
      check("add_done", 64'(bus.issueblk_done), 64'd1);
      cyc();
      drive(1'b0, 1'b1, 6'd0, ALU_ADD, 32'd0, 32'd0);
      #3;
      check("add_valid", 64'(bus.cdb_valid), 64'd1);
      check("add_tag",   64'(bus.cdb_tag),   64'h0A);
      check("add_data",  64'(bus.cdb_data),  64'd12);

      // ALU corner vectors, one every other cycle.
      for (int i = 0; i < 8; i++) begin
         cyc();
         drive(1'b1, 1'b1, 6'(8'h10 + i), vecs[i].op, vecs[i].a, vecs[i].b);
         #3;
         check("vec_done", 64'(bus.issueblk_done), 64'd1);
         cyc();
         drive(1'b0, 1'b1, 6'd0, ALU_ADD, 32'd0, 32'd0);
         #3;
         check("vec_valid", 64'(bus.cdb_valid), 64'd1);
         check("vec_tag",   64'(bus.cdb_tag),   64'(8'h10 + i));
         check("vec_data",  64'(bus.cdb_data),  64'(vecs[i].exp));
      end

      // Stall: grant withheld while the queue keeps offering tags 1, 2, 3.
      cyc();
      drive(1'b0, 1'b0, 6'd0, ALU_ADD, 32'd0, 32'd0);
      bcast_log.delete();
      tag_presented = 1;
      for (int c = 0; c < 4; c++) begin
         logic exp_done;
         exp_done = (c == 0) || (c == 1 && CAP == 2);
         cyc();
         drive(1'b1, 1'b0, 6'(tag_presented), ALU_ADD, 32'(tag_presented), 32'd100);
         #3;
         check("stall_done", 64'(bus.issueblk_done), 64'(exp_done));
         if (exp_done) tag_presented++;
      end
      // Release the grant; the queue advances on each observed done.
      for (int c = 0; c < 8 && tag_presented <= 3; c++) begin
         cyc();
         drive(1'b1, 1'b1, 6'(tag_presented), ALU_ADD, 32'(tag_presented), 32'd100);
         #3;
         if (bus.issueblk_done) tag_presented++;
      end
      check("stall_all_accepted", 64'(tag_presented), 64'd4);
      cyc();
      drive(1'b0, 1'b1, 6'd0, ALU_ADD, 32'd0, 32'd0);
      repeat (3) cyc();
      check_log("stall_bcast", 1, 3);

      // Back-to-back: 20 instructions with grant every cycle.
      bcast_log.delete();
      for (int i = 0; i < 20; i++) begin
         cyc();
         drive(1'b1, 1'b1, 6'(8'h20 + i), alu_op_e'(3'(i)), 32'(i * 32'h1111), 32'(i + 1));
         #3;
         check("b2b_done", 64'(bus.issueblk_done), 64'd1);
         if (i > 0) begin
            check("b2b_valid", 64'(bus.cdb_valid), 64'd1);
            check("b2b_tag",   64'(bus.cdb_tag),   64'(8'h20 + i - 1));
         end
      end
      cyc();
      drive(1'b0, 1'b1, 6'd0, ALU_ADD, 32'd0, 32'd0);
      #3;
      check("b2b_last_tag", 64'(bus.cdb_tag), 64'h33);
      repeat (2) cyc();
      check_log("b2b_bcast", 32'h20, 20);

      // Fill the buffer with grant withheld, then reset mid-operation.
      for (int c = 0; c < 3; c++) begin
         cyc();
         drive(1'b1, 1'b0, 6'(8'h30 + c), ALU_OR, 32'hDEAD_0000, 32'(c));
      end
      #3;
      check("fill_req", 64'(bus.cdb_req), 64'd1);
      cyc();
      #1;
      reset_n = 1'b0;
      drive(1'b0, 1'b0, 6'd0, ALU_ADD, 32'd0, 32'd0);
      #1;
      check("async_rst_req",   64'(bus.cdb_req),       64'd0);
      check("async_rst_valid", 64'(bus.cdb_valid),     64'd0);
      check("async_rst_tag",   64'(bus.cdb_tag),       64'd0);
      check("async_rst_data",  64'(bus.cdb_data),      64'd0);
      check("async_rst_done",  64'(bus.issueblk_done), 64'd0);
      repeat (2) cyc();
      reset_n = 1'b1;
      bcast_log.delete();

      // After reset no stale entry may appear, even with grant held.
      for (int c = 0; c < 5; c++) begin
         cyc();
         drive(1'b0, 1'b1, 6'd0, ALU_ADD, 32'd0, 32'd0);
      end
      #3;
      check("post_rst_req", 64'(bus.cdb_req), 64'd0);
      check_log("post_rst_stale", 0, 0);

      cyc();
      drive(1'b1, 1'b1, 6'h3F, ALU_ADD, 32'd1, 32'd2);
      #3;
      check("post_rst_done", 64'(bus.issueblk_done), 64'd1);
      cyc();
      drive(1'b0, 1'b1, 6'd0, ALU_ADD, 32'd0, 32'd0);
      #3;
      check("post_rst_tag",  64'(bus.cdb_tag),  64'h3F);
      check("post_rst_data", 64'(bus.cdb_data), 64'd3);
      cyc();
      drive(1'b0, 1'b0, 6'd0, ALU_ADD, 32'd0, 32'd0);
      repeat (2) cyc();
      check_log("post_rst_bcast", 32'h3F, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/integer_exec_unit.md
# integer_exec_unit

Integer execution block on the consumer side of the integer issue queue. It accepts one ready instruction per cycle from the queue with a single-cycle `issueblk_done` handshake, computes the ALU result, and holds it in a result buffer until the CDB arbiter grants the bus. It then broadcasts the result on the CDB (`cdb_valid` / `cdb_tag` / `cdb_data`), closing the wakeup loop back to the issue queues.

## Interface
Parameters:
- `XLEN`, 32: operand and result width.
- `TAG_W`, 6: physical destination tag width.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `issueque_ready`  in  1  queue has a ready instruction on its outputs.
- `issueque_rs_data`  in  XLEN  operand A.
- `issueque_rt_data`  in  XLEN  operand B.
- `issueque_rd_tag`  in  TAG_W  destination tag.
- `issueque_opcode`  in  3  ALU operation.
- `issueblk_done`  out  1  instruction accepted this cycle; the queue removes it at the same edge.
- `cdb_req`  out  1  result buffer non-empty, requesting the CDB.
- `cdb_grant`  in  1  arbiter grants the CDB this cycle.
- `cdb_valid`  out  1  broadcast valid (`cdb_req && cdb_grant`).
- `cdb_tag`  out  TAG_W  broadcast tag.
- `cdb_data`  out  XLEN  broadcast result.

## Operation
Opcodes, all results modulo 2^XLEN:
- 0 ADD: A+B.
- 1 SUB: A−B.
- 2 AND.
- 3 OR.
- 4 XOR.
- 5 SLL: A << B[4:0].
- 6 SRL: logical A >> B[4:0].
- 7 SLT: signed A<B, result is 1 or 0, zero-extended.

Result buffer:
- In-order FIFO of {tag, data} entries. Capacity `CAP` = 1, or 2 with `INT_EXEC_SKID_EN`.
- Occupancy states: EMPTY (0), HOLD (1), FULL (2, skid builds only).

Handshake:
- `issueblk_done = issueque_ready && (count < CAP || cdb_grant)`. This is combinational and never asserted without `issueque_ready`.
- On done, the ALU result for the presented operands is written to the buffer tail at the clock edge.

Broadcast:
- `cdb_req = (count != 0)`.
- `cdb_tag` and `cdb_data` always show the buffer head, and are 0 when the buffer is empty.
- A grant pops the head at the edge.
- A grant with `count == 0` is ignored. `cdb_valid` stays 0.

Occupancy transitions (accept = done, pop = `cdb_grant && count != 0`):
- accept only: count+1.
- pop only: count−1.
- both: count unchanged, and the new entry lands behind any remaining entry.
- neither: hold.

Other rules:
- FIFO order is strictly preserved. Results broadcast in acceptance order.
- Reset mid-operation discards buffered results without broadcasting them. The issue queue is reset by the same event.

## Timing
- Reset values: `issueblk_done` 0, `cdb_req` 0, `cdb_valid` 0, `cdb_tag` 0, `cdb_data` 0, count 0.
- Accept in cycle N gives `cdb_req` = 1 in cycle N+1. The earliest broadcast is cycle N+1, so accept-to-CDB latency is 1 cycle.
- Sustained throughput is 1 instruction per cycle while the CDB is granted every cycle, in both builds.
- Without the skid buffer: with the buffer HOLD and no grant, done is 0. Done reasserts in the cycle the grant arrives.
- No combinational path from the `issueque_*` data inputs to any `cdb_*` output.

## Configuration
- `INT_EXEC_SKID_EN` defined: `CAP` = 2. The unit keeps accepting for one extra cycle while a CDB grant is withheld, which hides one cycle of arbitration loss.
- Undefined: `CAP` = 1. State FULL does not exist and count is a single bit.

## Structure
- Shared package holds:
  - `alu_op_e`, a 3-bit enum ADD..SLT.
  - `cdb_entry_t` {tag, data}.
  - `TAG_W`.
- Sub-module `int_alu`: purely combinational (op, A, B → result). It is instantiated once, in front of the buffer write port.

## Test plan
- Reset release, `issueque_ready` = 0: all outputs 0 for 10 cycles. Then a grant pulse with an empty buffer → `cdb_valid` stays 0.
- Accept ADD 5+7, tag 0x0A, with grant held high → done in cycle N; `cdb_valid` = 1, tag 0x0A, data 12 in cycle N+1.
- SUB 0−1 → data 0xFFFFFFFF. SLT 0x80000000 vs 1 → data 1. SRL 0x80000000 by 31 → data 1. SLL using B = 0x21 → shift of 1.
- Grant held 0 with continuous ready (tags 1, 2, 3):
  - non-skid build: done for tag 1 only;
  - skid build: done for tags 1 and 2, then done = 0.
  - Then release grant → broadcasts in order 1, 2 (3), with no loss or duplication.
- Back-to-back accepts with grant every cycle for 20 instructions → done every cycle; each tag appears exactly once, in order, one cycle after acceptance.
- Assert `reset_n` low while the buffer is FULL → outputs 0 asynchronously. After release, no stale tag is ever broadcast.
